// File: rtl/scoreboard_register_file.sv
// Integer register file with NRD combinational read ports and one write port.
// x0 is hardwired to zero. Optional write-to-read bypass. Per-register pending
// bits drive the busy outputs. After reset, a sweep clears x1..x(NREGS-1)
// before ready is raised.
module scoreboard_register_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      busy,
  input  logic                wen,
  input  logic [AW-1:0]       w,
  input  logic [XLEN-1:0]     d,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_idx;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic [NREGS-1:0]  r_pend;
  logic              w_run;
  logic              w_wr;
  logic              w_iss;
  logic [AW-1:0]     w_ra   [NRD];
  logic [NRD-1:0]    w_hit;

  assign w_run = (r_state == ST_RUN);
  assign w_wr  = w_run && wen && (w != '0);
  assign w_iss = w_run && issue_en && (issue_rd != '0);
  assign ready = w_run;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Leave INIT on the edge that clears the last register
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_INIT) && (r_idx == AW'(NREGS - 1))) w_state_nxt = ST_RUN;
  end

  // Sweep index, starts at 1 since x0 needs no clearing
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_idx <= AW'(1);
    else if (r_state == ST_INIT) r_idx <= r_idx + 1'b1;
  end

  // Register storage: sweep clears in INIT, writeback updates in RUN.
  // No reset here; the sweep provides initialisation and reads are gated until ready.
  always_ff @(posedge clk) begin
    if (!w_run)    r_regs[r_idx] <= '0;
    else if (w_wr) r_regs[w]     <= d;
  end

  // Pending bits: the issue set is applied after the writeback clear so a new producer wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      if (w_wr)  r_pend[w]        <= 1'b0;
      if (w_iss) r_pend[issue_rd] <= 1'b1;
    end
  end

  // Read ports with bypass and busy resolution, each port independent
  always_comb begin
    rdata = '0;
    busy  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_ra[i]  = ra[i*AW +: AW];
      w_hit[i] = BYPASS && wen && (w == w_ra[i]) && (w != '0);
      if (w_run && (w_ra[i] != '0)) begin
        rdata[i*XLEN +: XLEN] = w_hit[i] ? d : r_regs[w_ra[i]];
        busy[i]               = r_pend[w_ra[i]] & ~w_hit[i];
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file. Two instances, with and without
// bypass, share all inputs. Expectations are queued when stimulus is driven and
// popped when outputs are sampled, shortly after the falling edge.
module tb_scoreboard_register_file;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NRD*AW-1:0]   ra = '0;
  logic                wen = 1'b0;
  logic [AW-1:0]       w = '0;
  logic [XLEN-1:0]     d = '0;
  logic                issue_en = 1'b0;
  logic [AW-1:0]       issue_rd = '0;

  logic                rdy_a, rdy_b;
  logic [NRD*XLEN-1:0] rd_a, rd_b;
  logic [NRD-1:0]      bz_a, bz_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  scoreboard_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .ready(rdy_a), .ra(ra), .rdata(rd_a), .busy(bz_a),
    .wen(wen), .w(w), .d(d), .issue_en(issue_en), .issue_rd(issue_rd)
  );

  scoreboard_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .ready(rdy_b), .ra(ra), .rdata(rd_b), .busy(bz_b),
    .wen(wen), .w(w), .d(d), .issue_en(issue_en), .issue_rd(issue_rd)
  );

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Expectation pairs: bypass instance first, then non-bypass instance
  task automatic exp_rd(input string tag, input logic [31:0] ea, input logic [31:0] eb);
    push({tag, "_byp"}, ea);
    push({tag, "_nob"}, eb);
  endtask

  task automatic obs_rd(input int p);
    compare(rd_a[p*XLEN +: XLEN]);
    compare(rd_b[p*XLEN +: XLEN]);
  endtask

  task automatic obs_bz(input int p);
    compare({31'b0, bz_a[p]});
    compare({31'b0, bz_b[p]});
  endtask

  task automatic obs_rdy();
    compare({31'b0, rdy_a});
    compare({31'b0, rdy_b});
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  // Release reset and walk through the clearing sweep; optionally drive
  // writes and issues during INIT, which must have no effect.
  task automatic sweep(input bit junk);
    @(negedge clk);
    reset = 1'b0;
    if (junk) begin
      wen = 1'b1; w = 5'd5; d = 32'hDEADBEEF;
      issue_en = 1'b1; issue_rd = 5'd5;
      set_ra(5'd5, 5'd5);
    end
    for (int e = 1; e <= 31; e++) begin
      @(negedge clk);
      if (e == 31) begin
        wen = 1'b0;
        issue_en = 1'b0;
      end
      exp_rd("sweep_ready", (e == 31) ? 32'd1 : 32'd0, (e == 31) ? 32'd1 : 32'd0);
      exp_rd("sweep_rdata0", 32'd0, 32'd0);
      exp_rd("sweep_busy0", 32'd0, 32'd0);
      #1;
      obs_rdy();
      obs_rd(0);
      obs_bz(0);
    end
  endtask

  initial begin
    // Power-up reset
    repeat (2) @(negedge clk);
    set_ra(5'd5, 5'd7);
    exp_rd("rst_ready", 32'd0, 32'd0);
    exp_rd("rst_rdata0", 32'd0, 32'd0);
    exp_rd("rst_busy1", 32'd0, 32'd0);
    #1;
    obs_rdy(); obs_rd(0); obs_bz(1);

    sweep(1'b0);

    // Every register reads zero on both ports
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      set_ra(5'(r), 5'(r));
      exp_rd("init_zero_p0", 32'd0, 32'd0);
      exp_rd("init_zero_p1", 32'd0, 32'd0);
      #1;
      obs_rd(0); obs_rd(1);
    end

    // Pre-load x5=1, then reset and sweep with a write to x5 attempted during INIT
    @(negedge clk);
    wen = 1'b1; w = 5'd5; d = 32'd1; set_ra(5'd0, 5'd0);
    @(negedge clk);
    wen = 1'b0; set_ra(5'd5, 5'd0);
    exp_rd("preload_x5", 32'd1, 32'd1);
    #1;
    obs_rd(0);
    @(negedge clk);
    reset = 1'b1;
    exp_rd("rst2_ready", 32'd0, 32'd0);
    #1;
    obs_rdy();
    sweep(1'b1);
    @(negedge clk);
    set_ra(5'd5, 5'd5);
    exp_rd("x5_after_init", 32'd0, 32'd0);
    exp_rd("x5_busy_after_init", 32'd0, 32'd0);
    #1;
    obs_rd(0); obs_bz(1);

    // RUN write with same-cycle read
    @(negedge clk);
    wen = 1'b1; w = 5'd5; d = 32'hDEADBEEF; set_ra(5'd5, 5'd0);
    exp_rd("bypass_x5", 32'hDEADBEEF, 32'd0);
    #1;
    obs_rd(0);
    @(negedge clk);
    wen = 1'b0;
    exp_rd("stored_x5", 32'hDEADBEEF, 32'hDEADBEEF);
    #1;
    obs_rd(0);

    // Writes to x0 are discarded
    @(negedge clk);
    wen = 1'b1; w = 5'd0; d = 32'hFFFFFFFF; set_ra(5'd0, 5'd0);
    exp_rd("x0_during_write", 32'd0, 32'd0);
    #1;
    obs_rd(0);
    @(negedge clk);
    wen = 1'b0;
    exp_rd("x0_after_write", 32'd0, 32'd0);
    exp_rd("x0_busy", 32'd0, 32'd0);
    #1;
    obs_rd(0); obs_bz(0);

    // Issue to x7: busy from the next cycle until writeback
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd7; set_ra(5'd0, 5'd7);
    exp_rd("busy7_issue_cycle", 32'd0, 32'd0);
    #1;
    obs_bz(1);
    @(negedge clk);
    issue_en = 1'b0;
    exp_rd("busy7_next", 32'd1, 32'd1);
    #1;
    obs_bz(1);
    @(negedge clk);
    exp_rd("busy7_hold", 32'd1, 32'd1);
    #1;
    obs_bz(1);
    @(negedge clk);
    wen = 1'b1; w = 5'd7; d = 32'h12;
    exp_rd("busy7_wb_cycle", 32'd0, 32'd1);
    exp_rd("rdata7_wb_cycle", 32'h12, 32'd0);
    #1;
    obs_bz(1); obs_rd(1);
    @(negedge clk);
    wen = 1'b0;
    exp_rd("busy7_after_wb", 32'd0, 32'd0);
    exp_rd("rdata7_after_wb", 32'h12, 32'h12);
    #1;
    obs_bz(1); obs_rd(1);

    // Issue and write of x9 in one cycle: the pending bit stays set
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd9;
    wen = 1'b1; w = 5'd9; d = 32'hABCD1234; set_ra(5'd9, 5'd9);
    exp_rd("busy9_same_cycle", 32'd0, 32'd0);
    exp_rd("rdata9_same_cycle", 32'hABCD1234, 32'd0);
    #1;
    obs_bz(0); obs_rd(0);
    @(negedge clk);
    issue_en = 1'b0; wen = 1'b0;
    exp_rd("busy9_p0", 32'd1, 32'd1);
    exp_rd("busy9_p1", 32'd1, 32'd1);
    exp_rd("rdata9_p0", 32'hABCD1234, 32'hABCD1234);
    exp_rd("rdata9_p1", 32'hABCD1234, 32'hABCD1234);
    #1;
    obs_bz(0); obs_bz(1); obs_rd(0); obs_rd(1);

    // Reset mid-RUN with x3 pending and holding data
    @(negedge clk);
    wen = 1'b1; w = 5'd3; d = 32'h55;
    issue_en = 1'b1; issue_rd = 5'd3; set_ra(5'd3, 5'd0);
    @(negedge clk);
    wen = 1'b0; issue_en = 1'b0;
    exp_rd("x3_before_reset", 32'h55, 32'h55);
    exp_rd("busy3_before_reset", 32'd1, 32'd1);
    #1;
    obs_rd(0); obs_bz(0);
    @(negedge clk);
    reset = 1'b1;
    exp_rd("midrun_rst_ready", 32'd0, 32'd0);
    exp_rd("midrun_rst_busy3", 32'd0, 32'd0);
    exp_rd("midrun_rst_rdata3", 32'd0, 32'd0);
    #1;
    obs_rdy(); obs_bz(0); obs_rd(0);
    sweep(1'b0);
    @(negedge clk);
    exp_rd("x3_after_reinit", 32'd0, 32'd0);
    exp_rd("busy3_after_reinit", 32'd0, 32'd0);
    #1;
    obs_rd(0); obs_bz(0);

    // Every pushed expectation must have been consumed
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
